mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Consumer end of the EX/MEM pipeline register: the MEM stage of the 5-stage RV32I pipeline.
//  - Takes the *M signals, performs the data-memory load/store over a req/ready handshake and
//    aligns load data.
//  - Registers the results into the MEM/WB register (*W outputs).
//  - Stalls the pipeline while memory is busy.
// PARAMETERS
//  XLEN      32  datapath width
//  TIMEOUT   15  max WAIT cycles before bus error (4-bit counter)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  RegWriteM    in   1     register write enable from EX/MEM
//  ResultSrcM   in   2     00 ALU, 01 memory load, 10 PC+4
//  MemWriteM    in   1     store request
//  Funct3M      in   3     access size/sign (RV32I load/store funct3)
//  ALUResultM   in   XLEN  effective address / ALU result
//  WriteDataM   in   XLEN  store data (rs2)
//  RdM          in   5     destination register
//  PCPlus4M     in   XLEN  link value
//  dmem_req     out  1     memory request
//  dmem_we      out  1     1 = store
//  dmem_addr    out  XLEN  word-aligned address {ALUResultM[31:2],2'b00}
//  dmem_wdata   out  XLEN  lane-replicated store data
//  dmem_be      out  4     byte enables
//  dmem_rdata   in   XLEN  read word, valid when dmem_ready
//  dmem_ready   in   1     access completes this cycle
//  StallM       out  1     hold IF..M stages this cycle
//  RegWriteW, ResultSrcW[2], ALUResultW, ReadDataW, RdW[5], PCPlus4W   out  MEM/WB register
//  MisalignW    out  1     misaligned access trap flag (registered)
//  BusErrW      out  1     memory timeout flag (registered)
// BEHAVIOUR
//  Reset (async): state IDLE, wait counter 0, all *W outputs and flags 0. dmem_req drops
//    immediately, also mid-WAIT.
//  access = MemWriteM | (ResultSrcM==01).
//  Misaligned condition:
//    - halfword with addr[0]=1, or word with addr[1:0]!=0.
//    - Misaligned -> no dmem_req.
//    - W captures a bubble (RegWriteW=0) with MisalignW=1 for one cycle.
//    - No stall.
//  dmem_req = access & ~misaligned & state-appropriate, combinational from *M inputs.
//    Upstream holds *M stable while StallM=1.
//  FSM:
//    - IDLE: access & ready   -> complete same cycle (0 wait).
//    - IDLE: access & ~ready  -> WAIT, cnt=1.
//    - WAIT: ready            -> complete, IDLE.
//    - WAIT: ~ready & cnt==TIMEOUT -> abandon, BusErrW=1, bubble, IDLE.
//    - WAIT: else             -> cnt++.
//  StallM = dmem_req & ~dmem_ready & ~(state==WAIT & cnt==TIMEOUT).
//    Combinational, no registered delay.
//  W register update every cycle:
//    - StallM=1 -> bubble (RegWriteW=0; other fields don't-care but zeroed).
//    - Otherwise captures the *M values plus ReadDataW.
//    - Total latency M->W = 1 cycle + wait cycles.
//  Stores:
//    - SB: be = 0001<<a[1:0], wdata = {4{b}}.
//    - SH: be = 0011<<a[1:0], wdata = {2{h}}.
//    - SW: be = 1111.
//  Loads: pick lane by a[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW direct.
//    - dmem_be = 1111 for loads.
//    - Unknown funct3 treated as word.
//  A store never writes a register; RegWriteW passes RegWriteM (decoder guarantees 0).
// STRUCTURE
//  Package riscv_pkg:
//    - result_src_e (ALU/MEM/PC4).
//    - funct3 constants F3_LB..F3_LHU.
//    - mem_state_e {IDLE,WAIT}.
//  Sub-module lsu_align (combinational): store lane/be generation + load extract/extend.
//    FSM, counter and W register live in the top.
// TESTING
//  LW a=0x100, ready same cycle, rdata=0xDEADBEEF -> StallM never 1, next cycle ReadDataW=0xDEADBEEF.
//  LB a=0x103, rdata=0x80FFFFFF -> ReadDataW=0xFFFFFF80; LBU same -> 0x00000080.
//  SH a=0x102, data=0x1234ABCD, ready after 3 cycles -> be=1100, wdata=0xABCDABCD,
//    StallM=1 for 3 cycles, 3 bubbles in W.
//  LW a=0x101 -> no dmem_req, next cycle MisalignW=1, RegWriteW=0.
//  Ready never asserted -> StallM high 15 cycles, then BusErrW=1, state IDLE.
//  rst asserted in WAIT cycle 2 -> dmem_req, StallM and all *W outputs 0 immediately; next access starts from IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline memory stage.
//   result_src_e : write-back source select (ALU / memory load / PC+4)
//   F3_*         : RV32I load/store funct3 encodings
//   mem_state_e  : data-memory access FSM states
//   acc_size_e   : access size decoded from funct3
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // Unknown funct3 encodings fall back to a word access.
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane alignment.
//   store_i    : 1 = store access (drives byte enables), 0 = load
//   funct3_i   : RV32I access size/sign
//   addr_lo_i  : effective address bits [1:0]
//   wdata_i    : raw store data (rs2)
//   rdata_i    : raw memory read word
//   wdata_o    : lane-replicated store data
//   be_o       : byte enables (all ones for loads)
//   rdata_o    : extracted and sign/zero-extended load data
//   misalign_o : halfword on odd address or word on non-word address
module lsu_align
    import riscv_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    acc_size_e   size;
    logic        sext;
    logic [31:0] lane;

    always_comb begin
        size       = f3_size(funct3_i);
        sext       = ~funct3_i[2];
        // Shift the addressed byte lane down to bit 0.
        lane       = rdata_i >> {addr_lo_i, 3'b000};
        wdata_o    = wdata_i;
        be_o       = '1;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        case (size)
            SZ_BYTE: begin
                if (store_i) begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                rdata_o = {{24{sext & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                misalign_o = addr_lo_i[0];
                if (store_i) begin
                    be_o    = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                rdata_o = {{16{sext & lane[15]}}, lane[15:0]};
            end
            default: begin
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage RV32I pipeline: data-memory access over a
// req/ready handshake, load alignment, and the MEM/WB pipeline register.
//   clk, rst            : clock / async active-high reset
//   *M inputs           : EX/MEM register contents
//   dmem_*              : data-memory request port
//   StallM              : hold IF..M while the access is outstanding
//   *W outputs          : MEM/WB register, plus MisalignW / BusErrW trap flags
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic            StallM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic            MisalignW,
    output logic            BusErrW
);

    localparam logic [3:0] TMO = TIMEOUT[3:0];

    mem_state_e      state_q;
    logic [3:0]      cnt_q;
    logic            access;
    logic            misalign;
    logic            timeout_hit;
    logic            abandon;
    logic            bubble;
    logic [XLEN-1:0] load_data;

    lsu_align u_align (
        .store_i    (MemWriteM),
        .funct3_i   (Funct3M),
        .addr_lo_i  (ALUResultM[1:0]),
        .wdata_i    (WriteDataM),
        .rdata_i    (dmem_rdata),
        .wdata_o    (dmem_wdata),
        .be_o       (dmem_be),
        .rdata_o    (load_data),
        .misalign_o (misalign)
    );

    always_comb begin
        access      = MemWriteM | (ResultSrcM == RES_MEM);
        timeout_hit = (state_q == WAIT) & (cnt_q == TMO);
        // rst gates the request so it drops at once, even mid-WAIT.
        dmem_req    = access & ~misalign & ~rst;
        dmem_we     = MemWriteM;
        dmem_addr   = {ALUResultM[XLEN-1:2], 2'b00};
        StallM      = dmem_req & ~dmem_ready & ~timeout_hit;
        abandon     = timeout_hit & dmem_req & ~dmem_ready;
        bubble      = StallM | (access & misalign) | abandon;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dmem_req && !dmem_ready) begin
                        state_q <= WAIT;
                        cnt_q   <= 4'd1;
                    end
                end
                default: begin
                    if (dmem_ready || timeout_hit || !dmem_req) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            endcase

            RegWriteW  <= RegWriteM & ~bubble;
            ResultSrcW <= bubble ? '0 : ResultSrcM;
            ALUResultW <= bubble ? '0 : ALUResultM;
            ReadDataW  <= bubble ? '0 : load_data;
            RdW        <= bubble ? '0 : RdM;
            PCPlus4W   <= bubble ? '0 : PCPlus4M;
            MisalignW  <= access & misalign;
            BusErrW    <= abandon;
        end
    end

endmodule
